car_sensor_emulator: RTL and testbench

Drives the parking-lot photo-sensor lines `a` and `b` with the waveform of a car entering, a car exiting, or a pedestrian crossing either sensor. It is the stimulus side of the sensor interface: it produces the same `a`/`b` patterns the parking-lot detector consumes. Uses include bench-top demos on the FPGA board (switch/key-triggered) and self-checking loopback benches against the detector. A request/ready handshake launches one crossing at a time. A guaranteed idle gap after each crossing keeps successive objects separated.

---
 rtl/car_sensor_emulator.sv | 121 ++++++++++++
 tb/tb_car_sensor_emulator.sv | 135 +++++++++++++
 2 files changed

// File: rtl/car_sensor_emulator.sv
// Parking-lot photo-sensor stimulus generator: plays the a/b waveform of a car
// entering, a car exiting, or a pedestrian at either sensor, one crossing per request.
module car_sensor_emulator #(
  parameter int PHASE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] kind,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       a,
  output logic       b
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PH1  = 3'd1,
    S_PH2  = 3'd2,
    S_PH3  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam int MAX_CYCLES = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] PH_LOAD  = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  state_t        ps_r, ps_nxt_s;
  logic [1:0]    kind_r, kind_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          done_nxt_s;

  // {a,b} shown while in a given state; kind[0] selects the b-side-first variants.
  function automatic logic [1:0] pattern(input state_t st, input logic [1:0] k);
    logic [1:0] ab;
    ab = 2'b00;
    case (st)
      S_PH1:   ab = k[0] ? 2'b01 : 2'b10;
      S_PH2:   ab = k[1] ? 2'b00 : 2'b11;
      S_PH3: begin
        case (k)
          2'b00:   ab = 2'b01;
          2'b01:   ab = 2'b10;
          default: ab = 2'b00;
        endcase
      end
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

  assign ready = (ps_r == S_IDLE);
  assign busy  = ~ready;

  // Next-state, phase counter and done decode.
  always_comb begin
    ps_nxt_s   = ps_r;
    kind_nxt_s = kind_r;
    cnt_nxt_s  = cnt_r;
    done_nxt_s = 1'b0;
    case (ps_r)
      S_IDLE: begin
        if (start) begin
          ps_nxt_s   = S_PH1;
          kind_nxt_s = kind;
          cnt_nxt_s  = PH_LOAD;
        end else begin
          ps_nxt_s   = S_IDLE;
        end
      end
      S_PH1, S_PH2, S_PH3: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else if (kind_r[1] || (ps_r == S_PH3)) begin
          ps_nxt_s  = S_GAP;
          cnt_nxt_s = GAP_LOAD;
        end else begin
          ps_nxt_s  = (ps_r == S_PH1) ? S_PH2 : S_PH3;
          cnt_nxt_s = PH_LOAD;
        end
      end
      S_GAP: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
          ps_nxt_s   = S_IDLE;
          cnt_nxt_s  = CNT_ZERO;
          done_nxt_s = 1'b1;
        end
      end
      default: begin
        ps_nxt_s  = S_IDLE;
        cnt_nxt_s = CNT_ZERO;
      end
    endcase
  end

  // State and registered outputs; the sensor lines are loaded with the pattern of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_r   <= S_IDLE;
      kind_r <= 2'b00;
      cnt_r  <= CNT_ZERO;
      done   <= 1'b0;
      a      <= 1'b0;
      b      <= 1'b0;
    end else begin
      ps_r   <= ps_nxt_s;
      kind_r <= kind_nxt_s;
      cnt_r  <= cnt_nxt_s;
      done   <= done_nxt_s;
      {a, b} <= pattern(ps_nxt_s, kind_nxt_s);
    end
  end

endmodule

// File: tb/tb_car_sensor_emulator.sv
// Bench for car_sensor_emulator: two instances (P=2,G=3 and P=1,G=1) share stimulus
// and are compared every cycle against a per-crossing timeline model.
module tb_car_sensor_emulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] kind;
  logic       ready0, busy0, done0, a0, b0;
  logic       ready1, busy1, done1, a1, b1;

  always #5 clk = ~clk;

  car_sensor_emulator #(.PHASE_CYCLES(2), .GAP_CYCLES(3)) dut0 (
    .clk(clk), .reset(reset), .start(start), .kind(kind),
    .ready(ready0), .busy(busy0), .done(done0), .a(a0), .b(b0)
  );

  car_sensor_emulator #(.PHASE_CYCLES(1), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .kind(kind),
    .ready(ready1), .busy(busy1), .done(done1), .a(a1), .b(b1)
  );

  // Entries are {a,b,ready,done} for one cycle; empty queue means idle.
  localparam logic [3:0] IDLE_EXP = 4'b0010;
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic model_edge(input int id);
    logic [3:0] q[$];
    logic [3:0] cur;
    logic [1:0] pats[$];
    int p, g;
    if (id == 0) begin q = q0; p = 2; g = 3; end
    else begin q = q1; p = 1; g = 1; end
    cur = (q.size() != 0) ? q[0] : IDLE_EXP;
    if (q.size() != 0) void'(q.pop_front());
    if (reset) begin
      q.delete();
    end else if (start && cur[1]) begin
      case (kind)
        2'b00:   pats = '{2'b10, 2'b11, 2'b01};
        2'b01:   pats = '{2'b01, 2'b11, 2'b10};
        2'b10:   pats = '{2'b10};
        default: pats = '{2'b01};
      endcase
      foreach (pats[i]) repeat (p) q.push_back({pats[i], 2'b00});
      repeat (g) q.push_back(4'b0000);
      q.push_back(4'b0011);
    end
    if (id == 0) q0 = q; else q1 = q;
  endtask

  task automatic check(input int id, input logic a, input logic b, input logic ready,
                       input logic busy, input logic done);
    logic [3:0] exp;
    if (id == 0) exp = (q0.size() != 0) ? q0[0] : IDLE_EXP;
    else         exp = (q1.size() != 0) ? q1[0] : IDLE_EXP;
    n_cmp++;
    assert ({a, b, ready, done} === exp) else begin
      n_fail++;
      $error("FAIL dut%0d_abrd t=%0t observed {a,b,ready,done}=%b expected=%b",
             id, $time, {a, b, ready, done}, exp);
    end
    n_cmp++;
    assert (busy === ~exp[1]) else begin
      n_fail++;
      $error("FAIL dut%0d_busy t=%0t observed=%b expected=%b", id, $time, busy, ~exp[1]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check(0, a0, b0, ready0, busy0, done0);
    check(1, a1, b1, ready1, busy1, done1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; kind = 2'b00;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Car enter, then car exit.
    start = 1'b1; kind = 2'b00; tick();
    start = 1'b0; repeat (12) tick();
    start = 1'b1; kind = 2'b01; tick();
    start = 1'b0; repeat (12) tick();

    // Pedestrian a, then pedestrian b accepted on the done cycle.
    start = 1'b1; kind = 2'b10; tick();
    kind = 2'b11; repeat (6) tick();
    start = 1'b0; repeat (10) tick();

    // Requests and kind changes while busy are ignored.
    start = 1'b1; kind = 2'b00; tick();
    for (int i = 0; i < 8; i++) begin
      start = (i % 2 == 0);
      kind  = 2'(i + 1);
      tick();
    end
    start = 1'b0; repeat (12) tick();

    // Reset in the third cycle of a car-enter crossing, then a fresh crossing.
    start = 1'b1; kind = 2'b00; tick();
    start = 1'b0; repeat (2) tick();
    reset = 1'b1; tick();
    reset = 1'b0; tick();
    start = 1'b1; kind = 2'b00; tick();
    start = 1'b0; repeat (12) tick();

    // Reset and start together: the request is dropped.
    reset = 1'b1; start = 1'b1; kind = 2'b01; tick();
    reset = 1'b0; start = 1'b0; repeat (3) tick();

    // Randomised traffic with occasional resets.
    repeat (400) begin
      start = ($urandom_range(0, 3) == 0);
      kind  = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 60) == 0);
      tick();
    end
    reset = 1'b0; start = 1'b0;
    repeat (12) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
